td4_exec_ctrl: RTL

//  Execution controller for the 4-bit TD4 core. Owns the 16x8 program memory the core fetches from,
//  and gates core progress through a one-cycle clock-enable pulse (cpu_ce). Host-side command port

---
 rtl/td4_pkg.sv | 21 ++
 rtl/td4_exec_ctrl_if.sv | 27 ++
 rtl/td4_prog_mem.sv | 29 ++
 rtl/td4_exec_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared encodings and widths for the TD4 execution controller slice.
package td4_pkg;

  localparam int unsigned TD4_AW    = 4;
  localparam int unsigned TD4_DW    = 8;
  localparam int unsigned TD4_DEPTH = 16;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_HALT  = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_WRITE = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

endpackage

// File: rtl/td4_exec_ctrl_if.sv
// Host command port of the TD4 execution controller.
interface td4_exec_ctrl_if;
  import td4_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [TD4_AW-1:0] cmd_addr;
  logic [TD4_DW-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/td4_prog_mem.sv
// 16x8 program store: synchronous write and clear, asynchronous read for the core fetch.
module td4_prog_mem
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [TD4_AW-1:0] waddr,
  input  logic [TD4_DW-1:0] wdata,
  input  logic [TD4_AW-1:0] raddr,
  output logic [TD4_DW-1:0] rdata
);

  logic [TD4_DW-1:0] mem [TD4_DEPTH];

  // Write port; reset wipes the whole program.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TD4_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/td4_exec_ctrl.sv
// TD4 execution controller: run/halt/step FSM, run-rate prescaler, fetch breakpoint,
// program memory ownership. cpu_ce, bp_hit and cmd_err are same-cycle decodes of the
// registered state so the core sees the enable in the cycle the tick is due.
module td4_exec_ctrl
  import td4_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  td4_exec_ctrl_if.slave    cmd,
  input  logic [DIV_W-1:0]  div,
  input  logic              bp_en,
  input  logic [TD4_AW-1:0] bp_addr,
  input  logic [TD4_AW-1:0] cpu_addr,
  output logic [TD4_DW-1:0] cpu_data,
  output logic              cpu_ce,
  output logic              halted,
  output logic              bp_hit,
  output logic              cmd_err
);

  state_e           st, st_nxt;
  logic [DIV_W-1:0] pre, pre_nxt;
  logic             bp_skip, bp_skip_nxt;
  logic             mem_we;
  logic             cmd_acc;
  logic             bp_match;
  cmd_op_e          op;

  assign op            = cmd_op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = (st != ST_STEP);
  assign cmd_acc       = cmd.cmd_valid & (st != ST_STEP);
  assign bp_match      = bp_en & (cpu_addr == bp_addr);
  assign halted        = (st == ST_HALT);

  // State, prescaler and breakpoint-skip registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_HALT;
      pre     <= '0;
      bp_skip <= 1'b0;
    end else begin
      st      <= st_nxt;
      pre     <= pre_nxt;
      bp_skip <= bp_skip_nxt;
    end
  end

  // Next state, prescaler countdown, command decode and output pulses.
  always_comb begin
    st_nxt      = st;
    pre_nxt     = pre;
    bp_skip_nxt = bp_skip;
    cpu_ce      = 1'b0;
    bp_hit      = 1'b0;
    cmd_err     = 1'b0;
    mem_we      = 1'b0;

    case (st)
      ST_HALT: begin
        if (cmd_acc) begin
          case (op)
            CMD_RUN: begin
              st_nxt      = ST_RUN;
              pre_nxt     = div;
              bp_skip_nxt = 1'b1;
            end
            CMD_STEP:  st_nxt = ST_STEP;
            CMD_WRITE: mem_we = 1'b1;
            default:   ;
          endcase
        end
      end

      ST_RUN: begin
        if (pre == '0) begin
          pre_nxt = div;
          // Resuming from a breakpoint must execute that instruction once.
          if (bp_match && !bp_skip) begin
            bp_hit = 1'b1;
            st_nxt = ST_HALT;
          end else begin
            cpu_ce      = 1'b1;
            bp_skip_nxt = 1'b0;
          end
        end else begin
          pre_nxt = pre - DIV_W'(1);
        end

        if (cmd_acc) begin
          case (op)
            CMD_HALT:            st_nxt  = ST_HALT;
            CMD_STEP, CMD_WRITE: cmd_err = 1'b1;
            default:             ;
          endcase
        end
      end

      ST_STEP: begin
        cpu_ce = 1'b1;
        st_nxt = ST_HALT;
      end

      default: st_nxt = ST_HALT;
    endcase
  end

  td4_prog_mem u_prog_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (cmd.cmd_addr),
    .wdata (cmd.cmd_data),
    .raddr (cpu_addr),
    .rdata (cpu_data)
  );

endmodule
